// File: rtl/ysyx_22040729_pkg.sv
// Shared constants for the writeback path: result-source indices and
// the register-file geometry defaults.
package ysyx_22040729_pkg;

    localparam int REGI_DEPTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int N_SRC      = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

endpackage

// File: rtl/ysyx_22040729_RRArbiter.sv
// N-way round-robin arbiter: one-hot combinational grant searched from
// rr_ptr upward, pointer advances past the winner on every grant.
module ysyx_22040729_RRArbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_vld
);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040729_writeback_arbiter.sv
// Writeback arbiter: merges functional-unit results onto the single
// register-file write port and tracks per-register pending writes.
module ysyx_22040729_writeback_arbiter
    import ysyx_22040729_pkg::*;
#(
    parameter int REGI_DEPTH = ysyx_22040729_pkg::REGI_DEPTH,
    parameter int DATA_WIDTH = ysyx_22040729_pkg::DATA_WIDTH,
    parameter int N_SRC      = ysyx_22040729_pkg::N_SRC,
    localparam int AW        = $clog2(REGI_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_SRC-1:0]            src_valid,
    output logic [N_SRC-1:0]            src_ready,
    input  logic [N_SRC*AW-1:0]         src_rd,
    input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
    output logic                        rf_wen,
    output logic [AW-1:0]               rf_waddr,
    output logic [DATA_WIDTH-1:0]       rf_wdata,
    input  logic                        iss_valid,
    input  logic [AW-1:0]               iss_rd,
    input  logic [AW-1:0]               q_rs1,
    input  logic [AW-1:0]               q_rs2,
    input  logic [AW-1:0]               q_rd,
    output logic                        busy_rs1,
    output logic                        busy_rs2,
    output logic                        busy_rd,
    input  logic                        sb_clear
);

    logic [N_SRC-1:0]      grant;
    logic                  grant_vld;
    logic [AW-1:0]         sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic [REGI_DEPTH-1:1] pend_q;
    logic [REGI_DEPTH-1:1] pend_d;
    logic [REGI_DEPTH-1:0] pending;

    ysyx_22040729_RRArbiter #(
        .N (N_SRC)
    ) u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (src_valid),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    assign src_ready = grant;

    // Grant is one-hot, so an OR-mux is sufficient.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd   | src_rd[i*AW +: AW];
                sel_data = sel_data | src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_vld) begin
            rf_wen   <= (sel_rd != '0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // Clear is applied before set so a new producer keeps the register pending.
    always_comb begin
        pend_d = pend_q;
        for (int i = 1; i < REGI_DEPTH; i++) begin
            if (rf_wen && rf_waddr == AW'(i)) pend_d[i] = 1'b0;
            if (iss_valid && iss_rd == AW'(i)) pend_d[i] = 1'b1;
        end
        if (sb_clear) pend_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending  = {pend_q, 1'b0};
    assign busy_rs1 = pending[q_rs1];
    assign busy_rs2 = pending[q_rs2];
    assign busy_rd  = pending[q_rd];

endmodule

// File: tb/tb_ysyx_22040729_writeback_arbiter.sv
// Bench for the writeback arbiter: a behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ysyx_22040729_writeback_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int RD = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_rd;
    logic [N*DW-1:0] src_data;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   q_rs1, q_rs2, q_rd;
    logic            busy_rs1, busy_rs2, busy_rd;
    logic            sb_clear;

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    int            m_ptr = 0;
    bit            m_pend [RD];
    bit            m_wen = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;

    always #5 clk = ~clk;

    ysyx_22040729_writeback_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .q_rd      (q_rd),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_rd   (busy_rd),
        .sb_clear  (sb_clear)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (src_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_busy(input logic [AW-1:0] q);
        if (q == 0) return 1'b0;
        return m_pend[q];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            int g;
            g = model_grant();
            if (sb_clear) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else begin
                if (m_wen) m_pend[m_waddr] = 1'b0;
                if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            end
            if (g >= 0) begin
                m_waddr = src_rd[g*AW +: AW];
                m_wdata = src_data[g*DW +: DW];
                m_wen   = (m_waddr != 0);
                m_ptr   = (g + 1) % N;
            end else begin
                m_wen = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("model_src_ready", 64'(src_ready), 64'(er));
        chk("model_rf_wen",    64'(rf_wen),    64'(m_wen));
        chk("model_rf_waddr",  64'(rf_waddr),  64'(m_waddr));
        chk("model_rf_wdata",  rf_wdata,       m_wdata);
        chk("model_busy_rs1",  64'(busy_rs1),  64'(model_busy(q_rs1)));
        chk("model_busy_rs2",  64'(busy_rs2),  64'(model_busy(q_rs2)));
        chk("model_busy_rd",   64'(busy_rd),   64'(model_busy(q_rd)));
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        src_valid[i]        = v;
        src_rd[i*AW +: AW]  = rd;
        src_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst_n     = 1'b1;
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        q_rs1     = 5'd4;
        q_rs2     = 5'd9;
        q_rd      = 5'd5;
        sb_clear  = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_wen",   64'(rf_wen),   64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata,      64'd0);
        src_valid = 3'b110;
        #1 chk("rst_ready_follows_valid", 64'(src_ready), 64'b010);
        src_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ALU write
        set_src(0, 1'b1, 5'd5, 64'h1234);
        @(negedge clk);
        chk("t1_ready", 64'(src_ready), 64'b001);
        chk("t1_busy0", 64'(busy_rd),   64'd0);
        nxt();
        src_valid = '0;
        @(negedge clk);
        chk("t1_wen",   64'(rf_wen),   64'd1);
        chk("t1_waddr", 64'(rf_waddr), 64'd5);
        chk("t1_wdata", rf_wdata,      64'h1234);
        chk("t1_busy1", 64'(busy_rd),  64'd0);
        nxt();

        // Write to x0 is consumed but discarded
        set_src(1, 1'b1, 5'd0, 64'hFFFF);
        q_rd = 5'd0;
        @(negedge clk);
        chk("x0_ready", 64'(src_ready), 64'b010);
        nxt();
        src_valid = '0;
        @(negedge clk);
        chk("x0_wen",  64'(rf_wen),  64'd0);
        chk("x0_busy", 64'(busy_rd), 64'd0);
        nxt();

        // Scoreboard lifecycle on x7
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        q_rd      = 5'd7;
        @(negedge clk);
        chk("sb_c0_busy", 64'(busy_rd), 64'd0);
        nxt();
        iss_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("sb_pending", 64'(busy_rd), 64'd1);
            nxt();
        end
        set_src(2, 1'b1, 5'd7, 64'hABCD);
        @(negedge clk);
        chk("sb_c4_ready", 64'(src_ready), 64'b100);
        chk("sb_c4_busy",  64'(busy_rd),   64'd1);
        nxt();
        src_valid = '0;
        @(negedge clk);
        chk("sb_c5_wen",   64'(rf_wen),   64'd1);
        chk("sb_c5_waddr", 64'(rf_waddr), 64'd7);
        chk("sb_c5_busy",  64'(busy_rd),  64'd1);
        nxt();
        @(negedge clk);
        chk("sb_c6_busy", 64'(busy_rd), 64'd0);
        nxt();

        // Set and clear of x9 in the same cycle, then flush
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        q_rd      = 5'd9;
        nxt();
        iss_valid = 1'b0;
        set_src(0, 1'b1, 5'd9, 64'h99);
        nxt();
        src_valid = '0;
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        @(negedge clk);
        chk("coll_wen",   64'(rf_wen),   64'd1);
        chk("coll_waddr", 64'(rf_waddr), 64'd9);
        chk("coll_busy",  64'(busy_rd),  64'd1);
        nxt();
        iss_valid = 1'b0;
        sb_clear  = 1'b1;
        @(negedge clk);
        chk("coll_set_wins", 64'(busy_rd), 64'd1);
        nxt();
        sb_clear = 1'b0;
        @(negedge clk);
        chk("sb_clear_busy",  64'(busy_rd),  64'd0);
        chk("sb_clear_rs2",   64'(busy_rs2), 64'd0);
        nxt();

        // Async reset between edges with a write in flight
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        q_rd      = 5'd4;
        nxt();
        iss_valid = 1'b0;
        set_src(0, 1'b1, 5'd6, 64'h66);
        nxt();
        src_valid = '0;
        @(negedge clk);
        chk("ar_pre_wen",  64'(rf_wen),  64'd1);
        chk("ar_pre_busy", 64'(busy_rd), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wen",   64'(rf_wen),   64'd0);
        chk("ar_busy",  64'(busy_rd),  64'd0);
        chk("ar_waddr", 64'(rf_waddr), 64'd0);

        // Contention from a fresh pointer
        set_src(0, 1'b1, 5'd1, 64'h11);
        set_src(1, 1'b1, 5'd2, 64'h22);
        set_src(2, 1'b1, 5'd3, 64'h33);
        #1 chk("ar_ready_in_reset", 64'(src_ready), 64'b001);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            logic [N-1:0] exp_ready;
            exp_ready = '0;
            exp_ready[k % 3] = 1'b1;
            @(negedge clk);
            if (k < 6) chk("cont_ready", 64'(src_ready), 64'(exp_ready));
            if (k >= 1) begin
                chk("cont_wen",   64'(rf_wen),   64'd1);
                chk("cont_waddr", 64'(rf_waddr), 64'(((k - 1) % 3) + 1));
            end
            nxt();
            if (k == 5) src_valid = '0;
        end
        @(negedge clk);
        chk("cont_idle_wen", 64'(rf_wen), 64'd0);
        nxt();
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
